// File: rtl/ex_mem_stage_if.sv
// Bundle between the ID/EX register, the execute stage and the EX/MEM register.
// The master side drives the ID/EX controls and consumes the EX/MEM results.
interface ex_mem_stage_if #(
    parameter int N = 32
);
    logic         Stall_i;
    logic         Flush_i;
    logic         Valid_i;
    logic [N-1:0] RD1_i;
    logic [N-1:0] RD2_i;
    logic [N-1:0] Extend_i;
    logic         RF_WE_i;
    logic [3:0]   A3_i;
    logic         BranchSelect_i;
    logic         ALUOpBSelect_i;
    logic [1:0]   ALUControl_i;
    logic         SetFlags_i;
    logic         MemWE_i;
    logic         WBSelect_i;

    logic [N-1:0] ALUResult_o;
    logic [N-1:0] WriteData_o;
    logic         RF_WE_o;
    logic [3:0]   A3_o;
    logic         MemWE_o;
    logic         WBSelect_o;
    logic         Valid_o;
    logic [3:0]   Flags_o;
    logic         BranchTaken_o;
    logic [N-1:0] BranchTarget_o;

    modport master (
        output Stall_i, Flush_i, Valid_i, RD1_i, RD2_i, Extend_i, RF_WE_i, A3_i,
               BranchSelect_i, ALUOpBSelect_i, ALUControl_i, SetFlags_i, MemWE_i, WBSelect_i,
        input  ALUResult_o, WriteData_o, RF_WE_o, A3_o, MemWE_o, WBSelect_o, Valid_o,
               Flags_o, BranchTaken_o, BranchTarget_o
    );

    modport slave (
        input  Stall_i, Flush_i, Valid_i, RD1_i, RD2_i, Extend_i, RF_WE_i, A3_i,
               BranchSelect_i, ALUOpBSelect_i, ALUControl_i, SetFlags_i, MemWE_i, WBSelect_i,
        output ALUResult_o, WriteData_o, RF_WE_o, A3_o, MemWE_o, WBSelect_o, Valid_o,
               Flags_o, BranchTaken_o, BranchTarget_o
    );
endinterface

// File: rtl/ex_mem_stage.sv
// Execute stage: operand-B mux, 4-op ALU with NZCV flags, branch resolve,
// and the EX/MEM pipeline register with flush/stall/bubble handling.
module ex_mem_stage #(
    parameter int N = 32
) (
    input logic           CLK,
    input logic           RST,
    ex_mem_stage_if.slave bus
);
    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_ORR = 2'b11
    } alu_op_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

    logic [N-1:0] op_b;
    logic [N:0]   wide_sum;
    logic [N-1:0] alu_result;
    nzcv_t        flags_q;
    nzcv_t        flags_next;
    logic         live;

    // Reset is folded in so a branch never fires while the core is held in reset.
    assign live = RST & bus.Valid_i & ~bus.Flush_i & ~bus.Stall_i;
    assign op_b = bus.ALUOpBSelect_i ? bus.Extend_i : bus.RD2_i;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        wide_sum     = '0;
        alu_result   = '0;
        flags_next   = flags_q;
        unique case (alu_op_e'(bus.ALUControl_i))
            ALU_ADD: begin
                wide_sum     = {1'b0, bus.RD1_i} + {1'b0, op_b};
                alu_result   = wide_sum[N-1:0];
                flags_next.c = wide_sum[N];
                flags_next.v = (bus.RD1_i[N-1] == op_b[N-1]) &&
                               (alu_result[N-1] != bus.RD1_i[N-1]);
            end
            ALU_SUB: begin
                // A + ~B + 1: carry out is set exactly when no borrow occurs.
                wide_sum     = {1'b0, bus.RD1_i} + {1'b0, ~op_b} + {{N{1'b0}}, 1'b1};
                alu_result   = wide_sum[N-1:0];
                flags_next.c = wide_sum[N];
                flags_next.v = (bus.RD1_i[N-1] != op_b[N-1]) &&
                               (alu_result[N-1] != bus.RD1_i[N-1]);
            end
            ALU_AND: alu_result = bus.RD1_i & op_b;
            ALU_ORR: alu_result = bus.RD1_i | op_b;
            default: alu_result = '0;
        endcase
        flags_next.n = alu_result[N-1];
        flags_next.z = (alu_result == '0);
    end

    assign bus.BranchTaken_o  = live & bus.BranchSelect_i;
    assign bus.BranchTarget_o = alu_result;
    assign bus.Flags_o        = flags_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            flags_q <= '0;
        end else if (live && bus.SetFlags_i) begin
            flags_q <= flags_next;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bus.ALUResult_o <= '0;
            bus.WriteData_o <= '0;
            bus.RF_WE_o     <= 1'b0;
            bus.A3_o        <= '0;
            bus.MemWE_o     <= 1'b0;
            bus.WBSelect_o  <= 1'b0;
            bus.Valid_o     <= 1'b0;
        end else if (bus.Flush_i) begin
            bus.ALUResult_o <= '0;
            bus.WriteData_o <= '0;
            bus.RF_WE_o     <= 1'b0;
            bus.A3_o        <= '0;
            bus.MemWE_o     <= 1'b0;
            bus.WBSelect_o  <= 1'b0;
            bus.Valid_o     <= 1'b0;
        end else if (!bus.Stall_i) begin
            bus.ALUResult_o <= alu_result;
            bus.WriteData_o <= bus.RD2_i;
            bus.RF_WE_o     <= bus.RF_WE_i & bus.Valid_i;
            bus.A3_o        <= bus.A3_i;
            bus.MemWE_o     <= bus.MemWE_i & bus.Valid_i;
            bus.WBSelect_o  <= bus.WBSelect_i;
            bus.Valid_o     <= bus.Valid_i;
        end
    end
endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed cases plus randomized traffic
// compared against an arithmetic reference model of the execute stage.
module tb_ex_mem_stage;
    logic CLK;
    logic RST;

    ex_mem_stage_if #(.N(32)) bus ();

    ex_mem_stage #(.N(32)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // Reference model of the registered state.
    logic [31:0] m_result, m_wdata;
    logic        m_rfwe, m_memwe, m_wbsel, m_valid;
    logic [3:0]  m_a3;
    logic [3:0]  m_flags;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_result = '0; m_wdata = '0; m_rfwe = 0; m_memwe = 0;
        m_wbsel = 0; m_valid = 0; m_a3 = '0; m_flags = '0;
    endtask

    // Result and NZCV from plain integer arithmetic.
    task automatic alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                           input logic [3:0] fin, output logic [31:0] r, output logic [3:0] fout);
        longint unsigned ua, ub;
        longint sa, sb, s;
        logic c, v;
        ua = {32'd0, a};
        ub = {32'd0, b};
        sa = $signed(a);
        sb = $signed(b);
        c = fin[1];
        v = fin[0];
        case (op)
            2'd0: begin
                r = a + b;
                c = (ua + ub) > 64'h0000_0000_FFFF_FFFF;
                s = sa + sb;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            2'd1: begin
                r = a - b;
                c = (a >= b);
                s = sa - sb;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            2'd2: r = a & b;
            default: r = a | b;
        endcase
        fout = {r[31], (r == 32'd0), c, v};
    endtask

    task automatic drive(input logic v, input logic fl, input logic st,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                         input logic bsel, input logic [1:0] op, input logic sf,
                         input logic br, input logic rfwe, input logic memwe,
                         input logic wbs, input logic [3:0] a3);
        bus.Valid_i = v; bus.Flush_i = fl; bus.Stall_i = st;
        bus.RD1_i = a; bus.RD2_i = b; bus.Extend_i = imm;
        bus.ALUOpBSelect_i = bsel; bus.ALUControl_i = op; bus.SetFlags_i = sf;
        bus.BranchSelect_i = br; bus.RF_WE_i = rfwe; bus.MemWE_i = memwe;
        bus.WBSelect_i = wbs; bus.A3_i = a3;
    endtask

    task automatic check_regs();
        check("alu_result", bus.ALUResult_o, m_result);
        check("write_data", bus.WriteData_o, m_wdata);
        check("rf_we", bus.RF_WE_o, m_rfwe);
        check("a3", bus.A3_o, m_a3);
        check("mem_we", bus.MemWE_o, m_memwe);
        check("wb_sel", bus.WBSelect_o, m_wbsel);
        check("valid", bus.Valid_o, m_valid);
        check("flags", bus.Flags_o, m_flags);
    endtask

    // Called with inputs already driven, shortly after a rising edge.
    task automatic cycle();
        logic [31:0] opb, r;
        logic [3:0]  nf;
        logic        live;
        opb  = bus.ALUOpBSelect_i ? bus.Extend_i : bus.RD2_i;
        alu_ref(bus.RD1_i, opb, bus.ALUControl_i, m_flags, r, nf);
        live = bus.Valid_i && !bus.Flush_i && !bus.Stall_i;
        #1;
        check("branch_taken", bus.BranchTaken_o, live && bus.BranchSelect_i);
        check("branch_target", bus.BranchTarget_o, r);
        @(posedge CLK);
        if (live && bus.SetFlags_i) m_flags = nf;
        if (bus.Flush_i) begin
            m_result = '0; m_wdata = '0; m_rfwe = 0; m_memwe = 0;
            m_wbsel = 0; m_valid = 0; m_a3 = '0;
        end else if (!bus.Stall_i) begin
            m_result = r;
            m_wdata  = bus.RD2_i;
            m_rfwe   = bus.RF_WE_i & bus.Valid_i;
            m_memwe  = bus.MemWE_i & bus.Valid_i;
            m_wbsel  = bus.WBSelect_i;
            m_valid  = bus.Valid_i;
            m_a3     = bus.A3_i;
        end
        #1;
        check_regs();
    endtask

    initial begin
        RST = 1'b0;
        model_reset();
        drive(0,0,0, 0,0,0, 0,2'd0,0, 0,0,0,0,4'd0);
        repeat (2) @(posedge CLK);
        #2 RST = 1'b1;
        @(posedge CLK); #1;
        check_regs();

        // Add with carry out: 0xFFFFFFFF + 1 -> 0, Z and C set.
        drive(1,0,0, 32'hFFFF_FFFF,32'd1,0, 0,2'd0,1, 0,1,0,0,4'd3);
        cycle();
        check("add_carry_result", bus.ALUResult_o, 32'd0);
        check("add_carry_flags", bus.Flags_o, 4'b0110);
        // orr without SetFlags leaves flags alone.
        drive(1,0,0, 0,0,0, 0,2'd3,0, 0,1,0,1,4'd4);
        cycle();
        check("orr_flags_held", bus.Flags_o, 4'b0110);

        // Subtract immediate: 0x80000000 - 1 overflows.
        drive(1,0,0, 32'h8000_0000,32'h55,32'd1, 1,2'd1,1, 0,1,0,0,4'd5);
        cycle();
        check("sub_ovf_result", bus.ALUResult_o, 32'h7FFF_FFFF);
        check("sub_ovf_flags", bus.Flags_o, 4'b0011);

        // Load 5+3, then stall twice with new inputs, then stall+flush.
        drive(1,0,0, 32'd5,32'd3,0, 0,2'd0,0, 0,1,1,0,4'd6);
        cycle();
        check("load_sum", bus.ALUResult_o, 32'd8);
        repeat (2) begin
            drive(1,0,1, $urandom,$urandom,$urandom, 0,2'd0,1, 1,1,1,1,4'd9);
            cycle();
            check("stall_hold", bus.ALUResult_o, 32'd8);
        end
        drive(1,1,1, 32'd1,32'd1,0, 0,2'd0,1, 0,1,1,0,4'd7);
        cycle();
        check("flush_valid", bus.Valid_o, 1'b0);
        check("flush_rfwe", bus.RF_WE_o, 1'b0);
        check("flush_memwe", bus.MemWE_o, 1'b0);
        check("flush_flags", bus.Flags_o, 4'b0011);

        // Branch resolve: target 0x100 + 0x20.
        drive(1,0,0, 32'h100,0,32'h20, 1,2'd0,0, 1,0,0,0,4'd0);
        #1;
        check("branch_taken_live", bus.BranchTaken_o, 1'b1);
        check("branch_target_val", bus.BranchTarget_o, 32'h120);
        cycle();
        drive(0,0,0, 32'h100,0,32'h20, 1,2'd0,0, 1,0,0,0,4'd0);
        cycle();
        drive(1,1,0, 32'h100,0,32'h20, 1,2'd0,0, 1,0,0,0,4'd0);
        cycle();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0,9) < 8, $urandom_range(0,9) == 0, $urandom_range(0,4) == 0,
                  ($urandom_range(0,7) == 0) ? 32'h8000_0000 : $urandom,
                  ($urandom_range(0,7) == 0) ? 32'hFFFF_FFFF : $urandom, $urandom,
                  1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom));
            cycle();
        end

        // Async reset mid-cycle with live inputs, stall and flush asserted.
        drive(1,1,1, 32'h1234,32'h5678,32'h9, 0,2'd1,1, 1,1,1,1,4'hF);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        model_reset();
        check_regs();
        check("reset_branch", bus.BranchTaken_o, 1'b0);
        drive(1,0,0, 32'h1234,32'h5678,32'h9, 0,2'd1,1, 1,1,1,1,4'hF);
        #1;
        check("reset_branch_live_in", bus.BranchTaken_o, 1'b0);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK); #1;
        drive(1,0,0, 32'd10,32'd10,0, 0,2'd1,1, 0,1,0,0,4'd2);
        cycle();
        check("post_reset_flags", bus.Flags_o, 4'b0110);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
